// File: rtl/gc_clk_mon_pkg.sv
// rtl/gc_clk_mon_pkg.sv - shared state type, default parameters and width helper for the clock lock monitor
package gc_clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        TRACK  = 2'd2,
        LOCKED = 2'd3
    } mon_state_t;

    localparam int DEF_EXP_COUNT = 3052;
    localparam int DEF_TOL       = 16;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_LOCK_GOOD = 4;
    localparam int DEF_LOSS_BAD  = 2;
    localparam int DEF_RST_HOLD  = 16;

    // Bits needed to hold 0..limit; never narrower than one bit.
    function automatic int rst_hold_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/gc_sync_edge.sv
// rtl/gc_sync_edge.sv - two-flop synchronizer with registered rising-edge pulse
module gc_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise_pulse
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta       <= 1'b0;
            sync       <= 1'b0;
            prev       <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            meta       <= async_in;
            sync       <= meta;
            prev       <= sync;
            rise_pulse <= sync & ~prev;
        end
    end

endmodule

// File: rtl/gc_clk_lock_monitor.sv
// rtl/gc_clk_lock_monitor.sv - reference-period lock qualifier; GC_LOCK_MON_PERIOD_OUT_EN enables PERIOD_COUNT/PERIOD_VALID
module gc_clk_lock_monitor
    import gc_clk_mon_pkg::*;
#(
    parameter int EXP_COUNT = DEF_EXP_COUNT,
    parameter int TOL       = DEF_TOL,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int LOCK_GOOD = DEF_LOCK_GOOD,
    parameter int LOSS_BAD  = DEF_LOSS_BAD,
    parameter int RST_HOLD  = DEF_RST_HOLD
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             REF_CLK_IN,
    input  logic             ENABLE,
    input  logic             FAULT_CLR,
    output logic             FAB_LOCK,
    output logic             RESET_OUT,
    output logic             FAULT,
    output logic [CNT_W-1:0] PERIOD_COUNT,
    output logic             PERIOD_VALID
);

    localparam int GOOD_W = rst_hold_w(LOCK_GOOD);
    localparam int BAD_W  = rst_hold_w(LOSS_BAD);
    localparam int HOLD_W = rst_hold_w(RST_HOLD);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_MAX - CNT_ONE;
    localparam logic [CNT_W:0]    EXP_X     = (CNT_W + 1)'(EXP_COUNT);
    localparam logic [CNT_W:0]    TOL_X     = (CNT_W + 1)'(TOL);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_GOOD - 1);
    localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(LOSS_BAD - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    mon_state_t        state;
    logic              ref_evt;
    logic              timeout;
    logic              win_end;
    logic              tracking;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  meas;
    logic [CNT_W:0]    meas_x;
    logic [CNT_W:0]    dev;
    logic              meas_good;
    logic              win_valid_q;
    logic              win_good_q;
    logic [GOOD_W-1:0] good_cnt;
    logic [BAD_W-1:0]  bad_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              lock_q;
    logic              rst_out_q;
    logic              fault_q;

    gc_sync_edge u_sync_edge (
        .clk        (FAB_CLK),
        .rst        (RESET),
        .async_in   (REF_CLK_IN),
        .rise_pulse (ref_evt)
    );

    // Deviation is taken one bit wider than the counter so it never wraps.
    always_comb begin
        timeout   = !ref_evt && (cnt == CNT_LAST);
        win_end   = ref_evt || timeout;
        tracking  = (state == TRACK) || (state == LOCKED);
        meas      = timeout ? CNT_MAX : cnt + CNT_ONE;
        meas_x    = {1'b0, meas};
        dev       = (meas_x >= EXP_X) ? meas_x - EXP_X : EXP_X - meas_x;
        meas_good = !timeout && (dev <= TOL_X);
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET || state == IDLE) begin
            cnt         <= '0;
            win_valid_q <= 1'b0;
            win_good_q  <= 1'b0;
        end else begin
            cnt         <= win_end ? '0 : cnt + CNT_ONE;
            win_valid_q <= win_end && tracking;
            win_good_q  <= meas_good;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state     <= IDLE;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            hold_cnt  <= '0;
            lock_q    <= 1'b0;
            rst_out_q <= 1'b1;
            fault_q   <= 1'b0;
        end else begin
            // The loss branch below assigns later, so a coincident set beats this clear.
            if (FAULT_CLR)
                fault_q <= 1'b0;
            if (!ENABLE) begin
                state     <= IDLE;
                good_cnt  <= '0;
                bad_cnt   <= '0;
                hold_cnt  <= '0;
                lock_q    <= 1'b0;
                rst_out_q <= 1'b1;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: if (win_end) state <= TRACK;
                    TRACK: begin
                        if (win_valid_q) begin
                            if (!win_good_q) begin
                                good_cnt <= '0;
                            end else if (good_cnt == GOOD_LAST) begin
                                state    <= LOCKED;
                                good_cnt <= '0;
                                bad_cnt  <= '0;
                                hold_cnt <= '0;
                                lock_q   <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + GOOD_W'(1);
                            end
                        end
                    end
                    LOCKED: begin
                        if (hold_cnt == HOLD_LAST)
                            rst_out_q <= 1'b0;
                        else
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        if (win_valid_q) begin
                            if (win_good_q) begin
                                bad_cnt <= '0;
                            end else if (bad_cnt == BAD_LAST) begin
                                state     <= TRACK;
                                good_cnt  <= '0;
                                bad_cnt   <= '0;
                                hold_cnt  <= '0;
                                lock_q    <= 1'b0;
                                rst_out_q <= 1'b1;
                                fault_q   <= 1'b1;
                            end else begin
                                bad_cnt <= bad_cnt + BAD_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign FAB_LOCK  = lock_q;
    assign RESET_OUT = rst_out_q;
    assign FAULT     = fault_q;

`ifdef GC_LOCK_MON_PERIOD_OUT_EN
    logic [CNT_W-1:0] period_q;

    always_ff @(posedge FAB_CLK) begin
        if (RESET)
            period_q <= '0;
        else if (state != IDLE && win_end && tracking)
            period_q <= meas;
    end

    assign PERIOD_COUNT = period_q;
    assign PERIOD_VALID = win_valid_q;
`else
    assign PERIOD_COUNT = '0;
    assign PERIOD_VALID = 1'b0;
`endif

endmodule
